// File: rtl/vid_timing_pkg.sv
// Shared types and helpers for the raster timing generator.
package vid_timing_pkg;

    localparam int CW = 16;

    // Shadow copy of the programmable raster timing.
    typedef struct packed {
        logic [CW-1:0] h_total;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_bporch;
        logic [CW-1:0] h_res;
        logic [CW-1:0] v_total;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_bporch;
        logic [CW-1:0] v_res;
        logic [CW-1:0] rd_hres;
        logic [CW-1:0] rd_vres;
        logic          hs_pol;
        logic          vs_pol;
    } vid_cfg_t;

    // True when lo <= cnt < lo+len; the upper bound is formed two bits wider
    // than a count so it can never wrap.
    function automatic logic in_win(input logic [CW-1:0] cnt,
                                    input logic [CW:0]   lo,
                                    input logic [CW-1:0] len);
        logic [CW+1:0] hi;
        hi = {1'b0, lo} + {2'b00, len};
        return ({2'b00, cnt} >= {1'b0, lo}) && ({2'b00, cnt} < hi);
    endfunction

endpackage

// File: rtl/vid_timing_axis.sv
// One raster axis: wrapping position counter plus sync/active/read decodes.
module vid_timing_axis
    import vid_timing_pkg::*;
(
    input  logic          video_clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [CW-1:0] total_i,
    input  logic [CW-1:0] sync_i,
    input  logic [CW:0]   act_lo_i,
    input  logic [CW-1:0] act_len_i,
    input  logic [CW:0]   rd_lo_i,
    input  logic [CW-1:0] rd_len_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o,
    output logic          sync_o,
    output logic          act_o,
    output logic          rd_o
);

    localparam logic [CW-1:0] ONE = 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last;

    assign last   = (cnt_q == (total_i - ONE));
    assign wrap_o = en_i & last;
    assign cnt_o  = cnt_q;
    assign sync_o = (cnt_q < sync_i);
    assign act_o  = in_win(cnt_q, act_lo_i, act_len_i);
    assign rd_o   = in_win(cnt_q, rd_lo_i, rd_len_i);

    // Next count: clear wins, otherwise advance and wrap at total-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last ? '0 : cnt_q + ONE;
        end
    end

    // Position register.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vid_timing_gen.sv
// Programmable raster timing generator with a leading frame-buffer read window.
module vid_timing_gen #(
    parameter int CW      = 16,
    parameter int RD_LEAD = 2
) (
    input  logic          video_clk,
    input  logic          rst_n,
    input  logic [CW-1:0] I_h_total,
    input  logic [CW-1:0] I_h_sync,
    input  logic [CW-1:0] I_h_bporch,
    input  logic [CW-1:0] I_h_res,
    input  logic [CW-1:0] I_v_total,
    input  logic [CW-1:0] I_v_sync,
    input  logic [CW-1:0] I_v_bporch,
    input  logic [CW-1:0] I_v_res,
    input  logic [CW-1:0] I_rd_hres,
    input  logic [CW-1:0] I_rd_vres,
    input  logic          I_hs_pol,
    input  logic          I_vs_pol,
    output logic          O_hs,
    output logic          O_vs,
    output logic          O_de,
    output logic          O_rden,
    output logic          O_frame_start,
    output logic [CW-1:0] O_hcnt,
    output logic [CW-1:0] O_vcnt,
    output logic          O_cfg_err
);
    import vid_timing_pkg::*;

    localparam logic [CW:0] LEAD_W = (CW+1)'(RD_LEAD);

    vid_cfg_t      cfg_in;
    vid_cfg_t      cfg_q;
    logic          loaded_q;
    logic [CW:0]   ha, va, rd_h_lo;
    logic [CW+1:0] h_need, v_need;
    logic          cfg_bad, run, frame_end, load;
    logic [CW-1:0] hcnt, vcnt;
    logic          h_wrap, h_sync_act, h_act, h_rd;
    logic          v_sync_act, v_act, v_rd;
    logic          hs_idle, vs_idle;
    logic          hs_q, vs_q, de_q, rden_q, fs_q, err_q;
    logic [CW-1:0] hcnt_q, vcnt_q;

    always_comb begin
        cfg_in = '{h_total: I_h_total, h_sync: I_h_sync, h_bporch: I_h_bporch,
                   h_res: I_h_res, v_total: I_v_total, v_sync: I_v_sync,
                   v_bporch: I_v_bporch, v_res: I_v_res, rd_hres: I_rd_hres,
                   rd_vres: I_rd_vres, hs_pol: I_hs_pol, vs_pol: I_vs_pol};
    end

    assign ha      = {1'b0, cfg_q.h_sync} + {1'b0, cfg_q.h_bporch};
    assign va      = {1'b0, cfg_q.v_sync} + {1'b0, cfg_q.v_bporch};
    assign h_need  = {1'b0, ha} + {2'b00, cfg_q.h_res};
    assign v_need  = {1'b0, va} + {2'b00, cfg_q.v_res};
    // Only consumed while the config is valid, which guarantees ha >= RD_LEAD.
    assign rd_h_lo = ha - LEAD_W;

    assign cfg_bad = ({2'b00, cfg_q.h_total} < h_need) ||
                     ({2'b00, cfg_q.v_total} < v_need) ||
                     (cfg_q.rd_hres > cfg_q.h_res) ||
                     (cfg_q.rd_vres > cfg_q.v_res) ||
                     (ha < LEAD_W) ||
                     (cfg_q.h_total == '0) || (cfg_q.v_total == '0);

    // Counting only once a valid shadow config is in place.
    assign run     = loaded_q & ~cfg_bad;
    // Shadows follow the inputs whenever idle or broken, else only at frame end.
    assign load    = ~run | frame_end;
    // Inactive sync level before the first shadow load comes from the inputs.
    assign hs_idle = loaded_q ? ~cfg_q.hs_pol : ~I_hs_pol;
    assign vs_idle = loaded_q ? ~cfg_q.vs_pol : ~I_vs_pol;

    vid_timing_axis u_h_axis (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .en_i      (run),
        .clr_i     (~run),
        .total_i   (cfg_q.h_total),
        .sync_i    (cfg_q.h_sync),
        .act_lo_i  (ha),
        .act_len_i (cfg_q.h_res),
        .rd_lo_i   (rd_h_lo),
        .rd_len_i  (cfg_q.rd_hres),
        .cnt_o     (hcnt),
        .wrap_o    (h_wrap),
        .sync_o    (h_sync_act),
        .act_o     (h_act),
        .rd_o      (h_rd)
    );

    vid_timing_axis u_v_axis (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .en_i      (h_wrap),
        .clr_i     (~run),
        .total_i   (cfg_q.v_total),
        .sync_i    (cfg_q.v_sync),
        .act_lo_i  (va),
        .act_len_i (cfg_q.v_res),
        .rd_lo_i   (va),
        .rd_len_i  (cfg_q.rd_vres),
        .cnt_o     (vcnt),
        .wrap_o    (frame_end),
        .sync_o    (v_sync_act),
        .act_o     (v_act),
        .rd_o      (v_rd)
    );

    // Shadow config capture and first-load flag.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded_q <= 1'b0;
            cfg_q    <= '0;
        end else begin
            loaded_q <= 1'b1;
            if (load) begin
                cfg_q <= cfg_in;
            end
        end
    end

    // Registered outputs, all aligned to the registered raster position.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            rden_q <= 1'b0;
            fs_q   <= 1'b0;
            err_q  <= 1'b0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hs_q   <= run ? ~(h_sync_act ^ cfg_q.hs_pol) : hs_idle;
            vs_q   <= run ? ~(v_sync_act ^ cfg_q.vs_pol) : vs_idle;
            de_q   <= run & h_act & v_act;
            rden_q <= run & h_rd & v_rd;
            fs_q   <= run & (hcnt == '0) & (vcnt == '0);
            err_q  <= loaded_q & cfg_bad;
            hcnt_q <= hcnt;
            vcnt_q <= vcnt;
        end
    end

    // Until the first edge after reset the sync lines show the inactive input level.
    assign O_hs          = loaded_q ? hs_q : ~I_hs_pol;
    assign O_vs          = loaded_q ? vs_q : ~I_vs_pol;
    assign O_de          = de_q;
    assign O_rden        = rden_q;
    assign O_frame_start = fs_q;
    assign O_hcnt        = hcnt_q;
    assign O_vcnt        = vcnt_q;
    assign O_cfg_err     = err_q;

endmodule
